// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage definitions: divide opcode selects and divider FSM encoding.
package rv_pkg;

    // funct3[1:0] of the M-extension divide group
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_ST_IDLE  = 2'd0,
        DIV_ST_BUSY  = 2'd1,
        DIV_ST_FIXUP = 2'd2,
        DIV_ST_DONE  = 2'd3
    } div_state_e;

    function automatic logic div_op_is_unsigned(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic div_op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration; the divider reuses a single copy every cycle.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dvd_msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] rem_shift;
    logic [XLEN:0] diff;

    // One bit wider than the operands so the borrow doubles as the compare result
    assign rem_shift = {rem_i, dvd_msb_i};
    assign diff      = rem_shift - {1'b0, divisor_i};

    assign q_bit_o = ~diff[XLEN];
    assign rem_o   = q_bit_o ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle, valid/ready on both sides.
//   state | meaning
//   IDLE  | o_ready=1, waiting for a request
//   BUSY  | XLEN restoring iterations on operand magnitudes
//   FIXUP | apply recorded quotient/remainder signs
//   DONE  | o_valid=1, result held until i_ready
module iter_divider
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_opsel,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            rem_sel_q, rem_sel_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] step_rem;
    logic            step_q_bit;
    logic            sign1, sign2;
    logic            is_signed;
    logic            div_by_zero, sgn_ovf;
    logic [XLEN-1:0] q_fixed, r_fixed;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[XLEN-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

    assign is_signed   = ~div_op_is_unsigned(i_opsel);
    assign sign1       = is_signed & i_op1[XLEN-1];
    assign sign2       = is_signed & i_op2[XLEN-1];
    assign div_by_zero = (i_op2 == '0);
    assign sgn_ovf     = is_signed && (i_op1 == SMIN) && (i_op2 == '1);

    assign q_fixed = q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
    assign r_fixed = r_neg_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        rem_sel_d = rem_sel_q;
        result_d  = result_q;

        if (i_kill) begin
            state_d = DIV_ST_IDLE;
        end else begin
            case (state_q)
                DIV_ST_IDLE: begin
                    if (i_valid) begin
                        rem_sel_d = div_op_is_rem(i_opsel);
                        if (div_by_zero) begin
                            result_d = div_op_is_rem(i_opsel) ? i_op1 : '1;
                            state_d  = DIV_ST_DONE;
                        end else if (sgn_ovf) begin
                            result_d = div_op_is_rem(i_opsel) ? '0 : SMIN;
                            state_d  = DIV_ST_DONE;
                        end else begin
                            // Negating SMIN yields SMIN, which is the correct unsigned magnitude
                            dvd_d   = sign1 ? (~i_op1 + 1'b1) : i_op1;
                            dsr_d   = sign2 ? (~i_op2 + 1'b1) : i_op2;
                            rem_d   = '0;
                            count_d = CW'(XLEN - 1);
                            q_neg_d = sign1 ^ sign2;
                            r_neg_d = sign1;
                            state_d = DIV_ST_BUSY;
                        end
                    end
                end
                DIV_ST_BUSY: begin
                    // Quotient bits shift into the vacated dividend LSBs
                    dvd_d = {dvd_q[XLEN-2:0], step_q_bit};
                    rem_d = step_rem;
                    if (count_q == '0) begin
                        state_d = DIV_ST_FIXUP;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end
                DIV_ST_FIXUP: begin
                    result_d = rem_sel_q ? r_fixed : q_fixed;
                    state_d  = DIV_ST_DONE;
                end
                DIV_ST_DONE: begin
                    if (i_ready) begin
                        state_d = DIV_ST_IDLE;
                    end
                end
                default: begin
                    state_d = DIV_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= DIV_ST_IDLE;
            count_q   <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            rem_sel_q <= rem_sel_d;
            result_q  <= result_d;
        end
    end

    assign o_ready  = (state_q == DIV_ST_IDLE);
    assign o_valid  = (state_q == DIV_ST_DONE);
    assign o_busy   = (state_q != DIV_ST_IDLE);
    assign o_result = result_q;

endmodule
